// File: rtl/button_event_gen_if.sv
// ---------------------------------------------------------------------------
// button_event_gen_if
// Bundles the raw button levels and the conditioned event outputs of
// button_event_gen.
//   btn_raw       raw asynchronous button levels, 1 = pressed
//   btn_db        debounced levels, one bit per button
//   press_pulse   one-cycle pulse when the owning button's press is accepted
//   release_pulse one-cycle pulse when the owning button is released
//   long_pulse    one-cycle pulse when the owner has been held long enough
//   repeat_pulse  one-cycle periodic pulse while the owner is long-held
//   busy          a button currently owns the arbiter
//   owner_idx     index of the owning button, 0 when not busy
// Modports: master = button source / event consumer, slave = the conditioner.
// ---------------------------------------------------------------------------
interface button_event_gen_if #(
  parameter int NUM_BTN = 5
);
  localparam int OWNER_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] long_pulse;
  logic [NUM_BTN-1:0] repeat_pulse;
  logic               busy;
  logic [OWNER_W-1:0] owner_idx;

  modport master (
    output btn_raw,
    input  btn_db, press_pulse, release_pulse, long_pulse, repeat_pulse,
           busy, owner_idx
  );

  modport slave (
    input  btn_raw,
    output btn_db, press_pulse, release_pulse, long_pulse, repeat_pulse,
           busy, owner_idx
  );
endinterface

// File: rtl/button_event_gen.sv
// ---------------------------------------------------------------------------
// button_event_gen
// Push-button front end: synchronises and debounces every raw button, lets
// one button at a time own the event arbiter, and emits one-cycle press,
// release, long-press and auto-repeat pulses for the owner.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    button_event_gen_if.slave (raw levels in, debounced levels and
//          event pulses out; see the interface header)
// Build option:
//   BUTTON_REPEAT_EN  when defined, the LONG state emits repeat_pulse every
//                     REPEAT_CYCLES; when undefined repeat_pulse is tied low
//                     and the repeat counter is not built.
// ---------------------------------------------------------------------------
module button_event_gen #(
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input logic               clk,
  input logic               reset,
  button_event_gen_if.slave bus
);
  localparam int OWNER_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // Lowest-index set bit; the arbiter gives simultaneous rises to the lowest.
  function automatic logic [OWNER_W-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = OWNER_W'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
  logic [DB_W-1:0]    db_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] db_r;
  logic [NUM_BTN-1:0] db_q_r;
  logic [NUM_BTN-1:0] sync_last_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] fall_s;
  logic [NUM_BTN-1:0] owner_bit_s;
  logic [OWNER_W-1:0] lowest_s;
  logic               owner_fall_s;

  logic [1:0]         state_r;
  logic [OWNER_W-1:0] owner_r;
  logic               busy_r;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] release_r;
  logic [NUM_BTN-1:0] long_r;

  assign sync_last_s  = sync_r[SYNC_STAGES-1];
  assign rise_s       = db_r & ~db_q_r;
  assign fall_s       = ~db_r & db_q_r;
  assign owner_bit_s  = NUM_BTN'(1) << owner_r;
  assign owner_fall_s = fall_s[owner_r];
  assign lowest_s     = lowest_set(rise_s);

  // Plain shift-register synchroniser, nothing ahead of the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= bus.btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Per-bit debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_last_s[i] == db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= sync_last_s[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced levels for rise/fall detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q_r <= '0;
    end else begin
      db_q_r <= db_r;
    end
  end

  // Ownership arbiter. Release is tested before the long threshold so a
  // release coinciding with it produces only release_pulse. Rises seen while
  // busy are dropped, never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      owner_r    <= '0;
      busy_r     <= 1'b0;
      hold_cnt_r <= '0;
      press_r    <= '0;
      release_r  <= '0;
      long_r     <= '0;
    end else begin
      press_r   <= '0;
      release_r <= '0;
      long_r    <= '0;
      case (state_r)
        ST_IDLE: begin
          if (|rise_s) begin
            owner_r    <= lowest_s;
            press_r    <= NUM_BTN'(1) << lowest_s;
            hold_cnt_r <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_HELD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (owner_fall_s) begin
            release_r <= owner_bit_s;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            state_r   <= ST_IDLE;
          end else if (hold_cnt_r == HOLD_LAST) begin
            long_r  <= owner_bit_s;
            state_r <= ST_LONG;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          // hold counter is frozen here; only release leaves this state
          if (owner_fall_s) begin
            release_r <= owner_bit_s;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_LONG;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          owner_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0]   rep_cnt_r;
  logic [NUM_BTN-1:0] repeat_r;

  // Auto-repeat: counter restarts on entry to LONG, pulses each time it wraps;
  // a release in the wrap cycle suppresses the repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_r <= '0;
      repeat_r  <= '0;
    end else begin
      repeat_r <= '0;
      if ((state_r == ST_HELD) && !owner_fall_s && (hold_cnt_r == HOLD_LAST)) begin
        rep_cnt_r <= '0;
      end else if ((state_r == ST_LONG) && !owner_fall_s) begin
        if (rep_cnt_r == REP_LAST) begin
          rep_cnt_r <= '0;
          repeat_r  <= owner_bit_s;
        end else begin
          rep_cnt_r <= rep_cnt_r + REP_W'(1);
        end
      end else begin
        rep_cnt_r <= rep_cnt_r;
      end
    end
  end

  assign bus.repeat_pulse = repeat_r;
`else
  assign bus.repeat_pulse = '0;
`endif

  assign bus.btn_db        = db_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.long_pulse    = long_r;
  assign bus.busy          = busy_r;
  assign bus.owner_idx     = owner_r;
endmodule

// File: tb/tb_button_event_gen.sv
// ---------------------------------------------------------------------------
// tb_button_event_gen
// Directed bench for button_event_gen with NUM_BTN=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8. Raw levels applied
// before edge 0 give btn_db after edge 5 and press_pulse after edge 6.
// Repeat expectations follow BUTTON_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_button_event_gen;
  localparam int NB = 4;

`ifdef BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_event_gen_if #(.NUM_BTN(NB)) bus ();

  button_event_gen #(
    .NUM_BTN(NB), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] db;
    logic [3:0] press;
    logic [3:0] rel;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge; pulses must be one-hot.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones({bus.press_pulse, bus.release_pulse,
                                  bus.long_pulse, bus.repeat_pulse})) <= 32'd1, 32'd1);
  endtask

  task automatic add_vec(input logic rst, input logic [3:0] raw, input logic [3:0] db,
                         input logic [3:0] press, input logic [3:0] rel,
                         input logic busy, input logic [1:0] owner);
    vec_t v;
    v.rst = rst; v.raw = raw; v.db = db; v.press = press; v.rel = rel;
    v.busy = busy; v.owner = owner;
    vecs.push_back(v);
  endtask

  // Clean press of button b with raw held for 'hold' cycles, then idle tail.
  task automatic add_press_release(input int b, input int hold);
    logic [3:0] bv;
    logic       bz;
    bv = 4'b0001 << b;
    for (int k = 0; k <= hold + 7; k++) begin
      bz = (k >= 6) && (k < hold + 6);
      add_vec(1'b0,
              (k < hold) ? bv : 4'b0000,
              (k >= 5 && k < hold + 5) ? bv : 4'b0000,
              (k == 6) ? bv : 4'b0000,
              (k == hold + 6) ? bv : 4'b0000,
              bz,
              bz ? 2'(b) : 2'd0);
    end
  endtask

  // Raw set before edge 0; press expected after edge 6 and not before.
  task automatic expect_press(input string name, input logic [3:0] exp);
    for (int k = 0; k < 6; k++) begin
      step();
      chk({name, "_early"}, 32'(bus.press_pulse), 32'd0);
    end
    step();
    chk(name, 32'(bus.press_pulse), 32'(exp));
  endtask

  initial begin
    logic [7:0] bounce;
    bounce = 8'b0011_0011;  // bit k = raw[0] before edge k: 1,1,0,0,1,1,0,0

    reset = 1'b1;
    bus.btn_raw = 4'b0000;

    // ---- vector table ----
    add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add_press_release(1, 10);                      // clean press of button 1
    for (int k = 0; k < 8; k++) begin              // bouncing button 0
      add_vec(1'b0, {3'b000, bounce[k]}, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    add_press_release(0, 6);                       // stable after bounce
    add_press_release(3, 10);                      // short press, no long

    step();
    step();
    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      bus.btn_raw = vecs[i].raw;
      step();
      chk("tbl_db",      32'(bus.btn_db),        32'(vecs[i].db));
      chk("tbl_press",   32'(bus.press_pulse),   32'(vecs[i].press));
      chk("tbl_release", 32'(bus.release_pulse), 32'(vecs[i].rel));
      chk("tbl_long",    32'(bus.long_pulse),    32'd0);
      chk("tbl_repeat",  32'(bus.repeat_pulse),  32'd0);
      chk("tbl_busy",    32'(bus.busy),          32'(vecs[i].busy));
      chk("tbl_owner",   32'(bus.owner_idx),     32'(vecs[i].owner));
    end
    reset = 1'b0;

    // ---- long press with auto-repeat on button 2 ----
    bus.btn_raw = 4'b0100;
    expect_press("lr_press", 4'b0100);
    for (int c = 1; c <= 60; c++) begin
      step();
      chk("lr_long",    32'(bus.long_pulse),    (c == 20) ? 32'h4 : 32'h0);
      chk("lr_repeat",  32'(bus.repeat_pulse),
          (REP_EN && (c == 28 || c == 36)) ? 32'h4 : 32'h0);
      chk("lr_release", 32'(bus.release_pulse), (c == 43) ? 32'h4 : 32'h0);
      chk("lr_busy",    32'(bus.busy),          (c < 43) ? 32'd1 : 32'd0);
      if (c == 36) bus.btn_raw = 4'b0000;
    end

    // ---- release coinciding with the long threshold: release wins ----
    bus.btn_raw = 4'b0001;
    expect_press("rp_press", 4'b0001);
    for (int c = 1; c <= 25; c++) begin
      step();
      chk("rp_long",    32'(bus.long_pulse),    32'h0);
      chk("rp_release", 32'(bus.release_pulse), (c == 20) ? 32'h1 : 32'h0);
      if (c == 13) bus.btn_raw = 4'b0000;
    end

    // ---- arbitration ----
    bus.btn_raw = 4'b0101;
    expect_press("arb_press", 4'b0001);
    chk("arb_owner", 32'(bus.owner_idx), 32'd0);
    chk("arb_busy",  32'(bus.busy),      32'd1);
    bus.btn_raw = 4'b0111;                          // button 1 pressed while busy
    for (int c = 1; c <= 30; c++) begin
      step();
      chk("arb_nopress", 32'(bus.press_pulse),   32'h0);
      chk("arb_release", 32'(bus.release_pulse), (c == 17) ? 32'h1 : 32'h0);
      if (c == 10) begin
        chk("arb_db", 32'(bus.btn_db), 32'h7);
        bus.btn_raw = 4'b0110;                      // release 0, keep 1 and 2
      end
      if (c >= 17) chk("arb_idle", 32'(bus.busy), 32'd0);
    end
    bus.btn_raw = 4'b0000;
    for (int c = 0; c < 10; c++) step();
    bus.btn_raw = 4'b0100;
    expect_press("arb_repress", 4'b0100);
    chk("arb_owner2", 32'(bus.owner_idx), 32'd2);
    bus.btn_raw = 4'b0000;
    for (int c = 0; c < 10; c++) step();

    // ---- reset while button 1 is in LONG ----
    bus.btn_raw = 4'b0010;
    expect_press("rst_press", 4'b0010);
    for (int c = 0; c < 25; c++) step();
    reset = 1'b1;
    step();
    chk("rst_db",      32'(bus.btn_db),        32'h0);
    chk("rst_press0",  32'(bus.press_pulse),   32'h0);
    chk("rst_release", 32'(bus.release_pulse), 32'h0);
    chk("rst_long",    32'(bus.long_pulse),    32'h0);
    chk("rst_repeat",  32'(bus.repeat_pulse),  32'h0);
    chk("rst_busy",    32'(bus.busy),          32'd0);
    chk("rst_owner",   32'(bus.owner_idx),     32'd0);
    reset = 1'b0;
    expect_press("rst_repress", 4'b0010);
    chk("rst_owner1", 32'(bus.owner_idx), 32'd1);
    chk("rst_busy1",  32'(bus.busy),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
